// File: rtl/mem_resp_pkg.sv
// Shared encodings, state type and access-legality check for the data memory responder.
package mem_resp_pkg;

    // Access size encodings carried on req_size.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    // Responder FSM states.
    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    // Request fields captured at the accept handshake.
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        is_unsigned;
        logic [31:0] wdata;
    } req_t;

    // Flags misaligned, illegal-size and out-of-range accesses.
    // aw is log2 of the array depth in words; bytes at or above 4 << aw are out of range.
    function automatic logic access_err(input logic [31:0] addr,
                                        input logic [1:0]  size,
                                        input int unsigned aw);
        logic misalign;
        logic out_of_range;
        case (size)
            SZ_BYTE: misalign = 1'b0;
            SZ_HALF: misalign = addr[0];
            SZ_WORD: misalign = (addr[1:0] != 2'b00);
            default: misalign = 1'b1;
        endcase
        out_of_range = ((addr >> (aw + 2)) != 32'd0);
        return misalign | out_of_range;
    endfunction

endpackage

// File: rtl/data_mem_responder_lane_align.sv
// Little-endian byte-lane steering: store-side merge and load-side extract/extend.
module lane_align
    import mem_resp_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] wr_word,
    output logic [31:0] rd_value
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    // Merge right-aligned store data into the addressed lanes, keeping the other bytes.
    always_comb begin
        wr_word = old_word;
        case (size)
            SZ_BYTE: begin
                case (lane)
                    2'd0:    wr_word[7:0]   = wdata[7:0];
                    2'd1:    wr_word[15:8]  = wdata[7:0];
                    2'd2:    wr_word[23:16] = wdata[7:0];
                    default: wr_word[31:24] = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (lane[1]) begin
                    wr_word[31:16] = wdata[15:0];
                end else begin
                    wr_word[15:0] = wdata[15:0];
                end
            end
            SZ_WORD: wr_word = wdata;
            default: wr_word = old_word;
        endcase
    end

    // Pick the addressed byte / half out of the read word.
    always_comb begin
        case (lane)
            2'd0:    rd_byte = old_word[7:0];
            2'd1:    rd_byte = old_word[15:8];
            2'd2:    rd_byte = old_word[23:16];
            default: rd_byte = old_word[31:24];
        endcase
        rd_half = lane[1] ? old_word[31:16] : old_word[15:0];
    end

    // Sign- or zero-extend sub-word loads; word loads pass straight through.
    always_comb begin
        case (size)
            SZ_BYTE: rd_value = is_unsigned ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            SZ_HALF: rd_value = is_unsigned ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: rd_value = old_word;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Valid/ready memory-side responder with programmable latency over an internal word array.
module data_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    req_t            req_q;
    logic            rsp_valid_q;
    logic            rsp_err_q;
    logic [31:0]     rsp_rdata_q;

    logic [31:0]     mem [DEPTH_WORDS];

    logic [AW-1:0]   word_idx;
    logic [31:0]     old_word;
    logic [31:0]     wr_word;
    logic [31:0]     rd_value;
    logic            acc_err;
    logic            do_access;
    logic            mem_we;
    logic [31:0]     rsp_rdata_d;

    assign word_idx  = req_q.addr[AW+1:2];
    assign old_word  = mem[word_idx];
    assign acc_err   = access_err(req_q.addr, req_q.size, AW);
    assign do_access = (state_q == WAIT) && (cnt_q == '0);
    // A reset asserted at the commit edge must still suppress the store.
    assign mem_we    = do_access && req_q.we && !acc_err && !rst;

    lane_align u_lane_align (
        .old_word    (old_word),
        .wdata       (req_q.wdata),
        .lane        (req_q.addr[1:0]),
        .size        (req_q.size),
        .is_unsigned (req_q.is_unsigned),
        .wr_word     (wr_word),
        .rd_value    (rd_value)
    );

    // Response data: extended load value, or zero for stores and faulting accesses.
    always_comb begin
        rsp_rdata_d = '0;
        if (!acc_err && !req_q.we) begin
            rsp_rdata_d = rd_value;
        end
    end

    // Request / response FSM with latency counter and registered response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        req_q.we          <= req_we;
                        req_q.addr        <= req_addr;
                        req_q.size        <= req_size;
                        req_q.is_unsigned <= req_unsigned;
                        req_q.wdata       <= req_wdata;
                        cnt_q             <= CNT_INIT;
                        state_q           <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= acc_err;
                        rsp_rdata_q <= rsp_rdata_d;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= '0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Array write port; the array itself is deliberately never reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[word_idx] <= wr_word;
        end
    end

    assign req_ready = (state_q == IDLE) && !rst;
    assign busy      = (state_q != IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule
